// File: rtl/fft_r2sdf_stage.sv
// rtl/fft_r2sdf_stage.sv - radix-2 SDF DIF FFT stage; define FFT_STAGE_SAT_EN for clipping and sticky sat
module fft_r2sdf_stage #(
    parameter int DBW = 8,
    parameter int CBW = 3,
    parameter int STG = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [2*DBW*(1<<(CBW-1))-1:0]     trigon,
    input  logic                              in_vld,
    input  logic [2*DBW-1:0]                  din,
    output logic                              out_vld,
    output logic [2*DBW-1:0]                  dout,
    output logic                              sat,
    input  logic                              sat_clr
);

    localparam int D  = 1 << (CBW-1-STG);
    localparam int PB = CBW-1-STG;
    localparam int TW = CBW-1;
    localparam int MW = 2*DBW+1;
    localparam logic signed [MW-1:0] RND = MW'(1 << (DBW-3));

    logic [CBW-1:0]   cnt;
    logic             primed;
    logic             p;
    logic [2*DBW-1:0] dly [D];
    logic [2*DBW-1:0] head;
    logic [TW-1:0]    tw_idx;
    logic [2*DBW-1:0] tw;

    logic signed [DBW-1:0] h_re, h_im, x_re, x_im, w_re, w_im;
    logic signed [MW-1:0]  sum_re, sum_im, dif_re, dif_im;
    logic signed [MW-1:0]  mul_re, mul_im, sel_re, sel_im;
    logic [DBW-1:0]        res_re, res_im, pdf_re, pdf_im;
    logic                  unused_bits;

    assign p    = cnt[PB];
    assign head = dly[0];

    // Twiddle index walks the half-block position, spaced by the stage decimation.
    generate
        if (STG == CBW-1) begin : g_tw_last
            assign tw_idx = '0;
        end else begin : g_tw_idx
            assign tw_idx = TW'(cnt[PB-1:0]) << STG;
        end
    endgenerate

    assign tw   = trigon[tw_idx*(2*DBW) +: 2*DBW];
    assign h_re = head[DBW-1:0];
    assign h_im = head[2*DBW-1:DBW];
    assign x_re = din[DBW-1:0];
    assign x_im = din[2*DBW-1:DBW];
    assign w_re = tw[DBW-1:0];
    assign w_im = tw[2*DBW-1:DBW];

    // Butterfly and rotation kept exact at full width before the fit to DBW bits.
    always_comb begin
        sum_re = (MW'(h_re) + MW'(x_re) + MW'(1)) >>> 1;
        sum_im = (MW'(h_im) + MW'(x_im) + MW'(1)) >>> 1;
        dif_re = (MW'(h_re) - MW'(x_re) + MW'(1)) >>> 1;
        dif_im = (MW'(h_im) - MW'(x_im) + MW'(1)) >>> 1;
        mul_re = (MW'(h_re) * MW'(w_re) - MW'(h_im) * MW'(w_im) + RND) >>> (DBW-2);
        mul_im = (MW'(h_re) * MW'(w_im) + MW'(h_im) * MW'(w_re) + RND) >>> (DBW-2);
        sel_re = p ? sum_re : mul_re;
        sel_im = p ? sum_im : mul_im;
    end

`ifdef FFT_STAGE_SAT_EN
    localparam logic signed [MW-1:0] VMAX = MW'((1 << (DBW-1)) - 1);
    localparam logic signed [MW-1:0] VMIN = MW'(-(1 << (DBW-1)));

    logic c_sr, c_si, c_dr, c_di, clip_evt;

    function automatic logic [DBW:0] clip_fit(input logic signed [MW-1:0] v);
        if (v > VMAX)
            clip_fit = {1'b1, VMAX[DBW-1:0]};
        else if (v < VMIN)
            clip_fit = {1'b1, VMIN[DBW-1:0]};
        else
            clip_fit = {1'b0, v[DBW-1:0]};
    endfunction

    // Clip output and pushed difference; a diff clip only counts in the butterfly phase.
    always_comb begin
        {c_sr, res_re} = clip_fit(sel_re);
        {c_si, res_im} = clip_fit(sel_im);
        {c_dr, pdf_re} = clip_fit(dif_re);
        {c_di, pdf_im} = clip_fit(dif_im);
        clip_evt = c_sr | c_si | (p & (c_dr | c_di));
    end

    // Sticky saturation flag; a new clip wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat <= 1'b0;
        else if (in_vld && primed && clip_evt)
            sat <= 1'b1;
        else if (sat_clr)
            sat <= 1'b0;
    end

    assign unused_bits = ^{cnt, trigon};
`else
    assign res_re = sel_re[DBW-1:0];
    assign res_im = sel_im[DBW-1:0];
    assign pdf_re = dif_re[DBW-1:0];
    assign pdf_im = dif_im[DBW-1:0];
    assign sat    = 1'b0;

    assign unused_bits = ^{cnt, trigon, sel_re[MW-1:DBW], sel_im[MW-1:DBW],
                           dif_re[MW-1:DBW], dif_im[MW-1:DBW], sat_clr};
`endif

    // Sample counter and priming; nothing advances without an accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            primed <= 1'b0;
        end else if (in_vld) begin
            cnt <= cnt + CBW'(1);
            if (cnt[PB:0] == (PB+1)'(D-1))
                primed <= 1'b1;
        end
    end

    // Delay line: fill pushes the input, butterfly pushes the difference.
    always_ff @(posedge clk) begin
        if (in_vld) begin
            for (int i = 0; i < D-1; i++)
                dly[i] <= dly[i+1];
            dly[D-1] <= p ? {pdf_im, pdf_re} : din;
        end
    end

    // Registered output, qualified by acceptance once primed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            dout    <= '0;
        end else begin
            out_vld <= in_vld & primed;
            if (in_vld && primed)
                dout <= {res_im, res_re};
        end
    end

endmodule

// File: tb/tb_fft_r2sdf_stage.sv
// tb/tb_fft_r2sdf_stage.sv - randomized and directed bench for fft_r2sdf_stage
module tb_fft_r2sdf_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] trigon;
    logic        in_vld, in_vld2, sat_clr;
    logic [15:0] din, din2;
    logic        out_vld, out_vld2, sat, sat2;
    logic [15:0] dout, dout2;

    int n_chk = 0;
    int n_err = 0;

    int tw_re [4] = '{64, 45, 0, -45};
    int tw_im [4] = '{0, -45, -64, -45};

    int          xr0 [$];
    int          xi0 [$];
    int          xr1 [$];
    int          xi1 [$];
    bit          ev0, ev1, ms0, ms1;
    logic [15:0] ed0, ed1;
    logic [15:0] obs0 [$];
    logic [15:0] obs1 [$];
    logic [15:0] imp [$];
    int          m0, m1;

    fft_r2sdf_stage #(.DBW(8), .CBW(3), .STG(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .trigon(trigon), .in_vld(in_vld), .din(din),
        .out_vld(out_vld), .dout(dout), .sat(sat), .sat_clr(sat_clr)
    );

    fft_r2sdf_stage #(.DBW(8), .CBW(3), .STG(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .trigon(trigon), .in_vld(in_vld2), .din(din2),
        .out_vld(out_vld2), .dout(dout2), .sat(sat2), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int fitv(input int v, inout bit f);
        int w;
`ifdef FFT_STAGE_SAT_EN
        w = v;
        if (v > 127) begin
            w = 127;
            f = 1'b1;
        end else if (v < -128) begin
            w = -128;
            f = 1'b1;
        end
`else
        w = v & 255;
        if (w > 127)
            w = w - 256;
`endif
        return w;
    endfunction

    // Output produced by acceptance m: sums in the second half of each 2D block,
    // rotated differences of the previous block in the first half.
    function automatic logic [15:0] ref_out(input int qr[$], input int qi[$], input int m,
                                            input int d, input int stg, inout bit f);
        int blk, pos, a, c, yr, yi, dr, di, k;
        bit dummy;
        blk = m / (2*d);
        pos = m % (2*d);
        if (pos >= d) begin
            a  = blk*2*d + pos - d;
            c  = m;
            yr = fitv((qr[a] + qr[c] + 1) >>> 1, f);
            yi = fitv((qi[a] + qi[c] + 1) >>> 1, f);
            dr = fitv((qr[a] - qr[c] + 1) >>> 1, f);
            di = fitv((qi[a] - qi[c] + 1) >>> 1, f);
        end else begin
            dummy = 1'b0;
            a  = (blk-1)*2*d + pos;
            c  = a + d;
            dr = fitv((qr[a] - qr[c] + 1) >>> 1, dummy);
            di = fitv((qi[a] - qi[c] + 1) >>> 1, dummy);
            k  = pos << stg;
            yr = fitv((dr*tw_re[k] - di*tw_im[k] + 32) >>> 6, f);
            yi = fitv((dr*tw_im[k] + di*tw_re[k] + 32) >>> 6, f);
        end
        return {yi[7:0], yr[7:0]};
    endfunction

    function automatic logic [15:0] rnd_smp();
        int r, i;
        r = int'($urandom_range(0, 254)) - 127;
        i = int'($urandom_range(0, 254)) - 127;
        return {i[7:0], r[7:0]};
    endfunction

    // Reference model: records accepted samples and predicts the next output.
    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            xr0.delete(); xi0.delete(); xr1.delete(); xi1.delete();
            ev0 = 1'b0; ev1 = 1'b0; ms0 = 1'b0; ms1 = 1'b0;
        end else begin
            if (sat_clr) begin
                ms0 = 1'b0;
                ms1 = 1'b0;
            end
            ev0 = 1'b0;
            ev1 = 1'b0;
            if (in_vld) begin
                m0 = xr0.size();
                xr0.push_back(int'($signed(din[7:0])));
                xi0.push_back(int'($signed(din[15:8])));
                if (m0 >= 4) begin
                    ev0 = 1'b1;
                    ed0 = ref_out(xr0, xi0, m0, 4, 0, ms0);
                end
            end
            if (in_vld2) begin
                m1 = xr1.size();
                xr1.push_back(int'($signed(din2[7:0])));
                xi1.push_back(int'($signed(din2[15:8])));
                if (m1 >= 1) begin
                    ev1 = 1'b1;
                    ed1 = ref_out(xr1, xi1, m1, 1, 2, ms1);
                end
            end
        end
    end

    // Monitor on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (rst_n !== 1'bx) begin
            check("out_vld", 32'(out_vld), 32'(ev0));
            if (ev0) check("dout", 32'(dout), 32'(ed0));
            check("sat", 32'(sat), 32'(ms0));
            check("out_vld2", 32'(out_vld2), 32'(ev1));
            if (ev1) check("dout2", 32'(dout2), 32'(ed1));
            check("sat2", 32'(sat2), 32'(ms1));
            if (out_vld)  obs0.push_back(dout);
            if (out_vld2) obs1.push_back(dout2);
        end
    end

    task automatic drive(input bit v, input logic [15:0] x, input bit v2,
                         input logic [15:0] x2, input bit clr);
        @(negedge clk);
        #1;
        in_vld  = v;
        din     = x;
        in_vld2 = v2;
        din2    = x2;
        sat_clr = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, rnd_smp(), 1'b0, rnd_smp(), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        in_vld2 = 1'b0;
        sat_clr = 1'b0;
        #1;
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        obs0.delete();
        obs1.delete();
    endtask

    task automatic impulse(input bit stall);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, (i == 0) ? 16'h0040 : 16'h0000, 1'b0, 16'h0000, 1'b0);
            if (stall) drive(1'b0, rnd_smp(), 1'b0, 16'h0000, 1'b0);
        end
        idle(2);
    endtask

    initial begin
        rst_n   = 1'bx;
        in_vld  = 1'b0;
        in_vld2 = 1'b0;
        din     = '0;
        din2    = '0;
        sat_clr = 1'b0;
        for (int k = 0; k < 4; k++)
            trigon[16*k +: 16] = {8'(tw_im[k]), 8'(tw_re[k])};

        do_reset();

        // Impulse
        impulse(1'b0);
        check("imp_count", 32'(obs0.size()), 32'd12);
        check("imp_o0", 32'(obs0[0]), 32'h0020);
        check("imp_o1", 32'(obs0[1]), 32'h0000);
        check("imp_o4", 32'(obs0[4]), 32'h0020);
        check("imp_o5", 32'(obs0[5]), 32'h0000);
        imp = obs0;

        // Impulse with in_vld toggling
        do_reset();
        impulse(1'b1);
        check("stall_count", 32'(obs0.size()), 32'(imp.size()));
        for (int i = 0; i < imp.size(); i++)
            check("stall_seq", 32'(obs0[i]), 32'(imp[i]));

        // DC
        do_reset();
        for (int i = 0; i < 16; i++)
            drive(1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0);
        idle(2);
        for (int i = 0; i < 8; i++)
            check("dc_out", 32'(obs0[i]), (i < 4) ? 32'h0040 : 32'h0000);

        // Saturation / wrap corner
        do_reset();
        for (int i = 0; i < 16; i++)
            drive(1'b1, (i == 1) ? 16'h7f7f : (i == 5) ? 16'h8181 : 16'h0000,
                  1'b0, 16'h0000, 1'b0);
        idle(2);
`ifdef FFT_STAGE_SAT_EN
        check("sat_o5", 32'(obs0[5]), 32'h007f);
        check("sat_flag", 32'(sat), 32'd1);
`else
        check("wrap_o5", 32'(obs0[5]), 32'h00b3);
        check("wrap_flag", 32'(sat), 32'd0);
`endif
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("sat_cleared", 32'(sat), 32'd0);

        // Reset mid-frame
        do_reset();
        for (int i = 0; i < 3; i++)
            drive(1'b1, rnd_smp(), 1'b0, 16'h0000, 1'b0);
        do_reset();
        impulse(1'b0);
        check("mid_rst_count", 32'(obs0.size()), 32'(imp.size()));
        for (int i = 0; i < imp.size(); i++)
            check("mid_rst_seq", 32'(obs0[i]), 32'(imp[i]));

        // Last stage, D = 1
        do_reset();
        drive(1'b0, 16'h0000, 1'b1, 16'h000a, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 16'h0006, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0);
        idle(2);
        check("stg2_count", 32'(obs1.size()), 32'd2);
        check("stg2_sum", 32'(obs1[0]), 32'h0008);
        check("stg2_diff", 32'(obs1[1]), 32'h0002);

        // Random streams with gaps and occasional sat_clr
        do_reset();
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 9) < 7, rnd_smp(), $urandom_range(0, 9) < 6, rnd_smp(),
                  $urandom_range(0, 29) == 0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
